fingertip_locator: RTL and testbench

Upstream stage of the movement detector. Scans the per-pixel binary skin mask of each camera frame and finds the topmost horizontal skin run of at least MIN_RUN pixels. At end of frame it reports the run's centre as fingertip coordinates (oFT_X, oFT_Y) plus a found flag, with a one-cycle frame-complete strobe. These outputs drive iFT_X / iFT_Y / iDVAL / iFrame_En of the movement detector directly.

---
 rtl/fingertip_locator.sv | 194 +++++++++++++++++++
 tb/tb_fingertip_locator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fingertip_locator.sv
// fingertip_locator
// Scans a binary skin mask frame and reports the centre of the topmost,
// leftmost horizontal skin run that is at least MIN_RUN pixels long.
// Results are registered at end of frame together with a one-cycle strobe.

module fingertip_locator #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MIN_RUN  = 8
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iFrame_Start,
    input  logic       iDVAL,
    input  logic       iSkin,
    output logic [9:0] oFT_X,
    output logic [9:0] oFT_Y,
    output logic       oDVAL,
    output logic       oFrame_En
);

    localparam logic [9:0] X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [7:0] MIN_CNT = 8'(MIN_RUN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        RUN    = 3'd2,
        LOCKED = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [9:0]  x, x_next;
    logic [9:0]  y, y_next;
    logic [7:0]  run_cnt, run_cnt_next;
    logic [9:0]  run_start, run_start_next;
    logic [9:0]  cand_start, cand_start_next;
    logic [9:0]  cand_end, cand_end_next;
    logic [9:0]  cand_y, cand_y_next;

    // Per-pixel run tracking, valid whenever a pixel is being consumed
    logic        line_start;
    logic [7:0]  cnt_base;
    logic [7:0]  cnt_cur;
    logic [9:0]  start_cur;
    logic        last_pixel;
    logic        found;
    logic [10:0] centre_sum;

    // Run length and run start as seen after the current pixel; runs restart at x=0
    always_comb begin
        line_start = (x == 10'd0);
        cnt_base   = line_start ? 8'd0 : run_cnt;
        if (iSkin) begin
            cnt_cur = (cnt_base == 8'd255) ? 8'd255 : cnt_base + 8'd1;
        end else begin
            cnt_cur = 8'd0;
        end
        if (iSkin && cnt_base == 8'd0) begin
            start_cur = x;
        end else begin
            start_cur = run_start;
        end
    end

    // Next-state logic: counter advance, candidate capture and state transitions
    always_comb begin
        state_next      = state;
        x_next          = x;
        y_next          = y;
        run_cnt_next    = run_cnt;
        run_start_next  = run_start;
        cand_start_next = cand_start;
        cand_end_next   = cand_end;
        cand_y_next     = cand_y;
        last_pixel      = 1'b0;
        found           = 1'b0;

        case (state)
            IDLE: begin
                x_next         = 10'd0;
                y_next         = 10'd0;
                run_cnt_next   = 8'd0;
                run_start_next = 10'd0;
                if (iFrame_Start) begin
                    state_next = SCAN;
                end
            end

            DONE: begin
                x_next       = 10'd0;
                y_next       = 10'd0;
                run_cnt_next = 8'd0;
                // A new frame may start right behind the strobe
                state_next   = iFrame_Start ? SCAN : IDLE;
            end

            default: begin
                if (iFrame_Start) begin
                    // Abort: restart cleanly, the pixel in this cycle is dropped
                    state_next     = SCAN;
                    x_next         = 10'd0;
                    y_next         = 10'd0;
                    run_cnt_next   = 8'd0;
                    run_start_next = 10'd0;
                end else if (iDVAL) begin
                    run_cnt_next   = cnt_cur;
                    run_start_next = start_cur;
                    if (x == X_LAST) begin
                        x_next = 10'd0;
                        y_next = (y == Y_LAST) ? 10'd0 : y + 10'd1;
                    end else begin
                        x_next = x + 10'd1;
                    end

                    if (state == SCAN) begin
                        if (cnt_cur == MIN_CNT) begin
                            cand_y_next     = y;
                            cand_start_next = start_cur;
                            if (x == X_LAST) begin
                                // Qualified on the last column: run closes at line end
                                cand_end_next = X_LAST;
                                state_next    = LOCKED;
                            end else begin
                                state_next = RUN;
                            end
                        end
                    end else if (state == RUN) begin
                        if (!iSkin) begin
                            cand_end_next = x - 10'd1;
                            state_next    = LOCKED;
                        end else if (x == X_LAST) begin
                            cand_end_next = X_LAST;
                            state_next    = LOCKED;
                        end
                    end

                    found = (state_next == LOCKED);
                    if (x == X_LAST && y == Y_LAST) begin
                        last_pixel = 1'b1;
                        state_next = DONE;
                    end
                end
            end
        endcase
    end

    assign centre_sum = {1'b0, cand_start_next} + {1'b0, cand_end_next};

    // State, counters and candidate registers
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= IDLE;
            x          <= 10'd0;
            y          <= 10'd0;
            run_cnt    <= 8'd0;
            run_start  <= 10'd0;
            cand_start <= 10'd0;
            cand_end   <= 10'd0;
            cand_y     <= 10'd0;
        end else begin
            state      <= state_next;
            x          <= x_next;
            y          <= y_next;
            run_cnt    <= run_cnt_next;
            run_start  <= run_start_next;
            cand_start <= cand_start_next;
            cand_end   <= cand_end_next;
            cand_y     <= cand_y_next;
        end
    end

    // Output registers: updated on the edge that consumes the last pixel
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oFT_X     <= 10'd0;
            oFT_Y     <= 10'd0;
            oDVAL     <= 1'b0;
            oFrame_En <= 1'b0;
        end else begin
            oFrame_En <= last_pixel;
            if (last_pixel) begin
                oDVAL <= found;
                if (found) begin
                    oFT_X <= 10'(centre_sum >> 1);
                    oFT_Y <= cand_y_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fingertip_locator.sv
// Self-checking bench for fingertip_locator on a 16x8 frame, MIN_RUN=4.
// Frame results are queued when a frame is driven and compared on each strobe.

module tb_fingertip_locator;

    localparam int H = 16;
    localparam int V = 8;
    localparam int NPIX = H * V;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       dval;
    logic       skin;
    logic [9:0] ft_x;
    logic [9:0] ft_y;
    logic       ft_dval;
    logic       frame_en;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int r0, s0, e0;
        int r1, s1, e1;
        bit gap;
        int ex, ey;
        bit ed;
    } vec_t;

    typedef struct {
        int x, y;
        bit d;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    fingertip_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_RUN(4)) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iFrame_Start(frame_start),
        .iDVAL       (dval),
        .iSkin       (skin),
        .oFT_X       (ft_x),
        .oFT_Y       (ft_y),
        .oDVAL       (ft_dval),
        .oFrame_En   (frame_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit skin_at(input vec_t v, input int px, input int py);
        return (py == v.r0 && px >= v.s0 && px <= v.e0) ||
               (py == v.r1 && px >= v.s1 && px <= v.e1);
    endfunction

    task automatic pulse_start;
        frame_start = 1'b1;
        dval        = 1'b0;
        tick();
        frame_start = 1'b0;
    endtask

    // Drive the first n pixels of a frame in raster order
    task automatic drive_pixels(input vec_t v, input int n);
        for (int i = 0; i < n; i++) begin
            if (v.gap) begin
                dval = 1'b0;
                skin = 1'b0;
                tick();
            end
            dval = 1'b1;
            skin = skin_at(v, i % H, i / H);
            tick();
        end
        dval = 1'b0;
        skin = 1'b0;
    endtask

    // Strobe must be exactly one cycle wide, starting right after the last pixel
    task automatic check_strobe_timing(input int idx);
        chk($sformatf("strobe_latency[%0d]", idx), frame_en, 1);
        tick();
        chk($sformatf("strobe_width[%0d]", idx), frame_en, 0);
    endtask

    function automatic exp_t mk_exp(input int ex, input int ey, input bit ed);
        exp_t e;
        e.x = ex;
        e.y = ey;
        e.d = ed;
        return e;
    endfunction

    // Scoreboard consumer: every strobe pops one expected frame result
    always @(posedge clk) begin
        #1;
        if (frame_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: got strobe with x=%0d y=%0d dval=%0d, expected none",
                         ft_x, ft_y, ft_dval);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("frame_x", ft_x, e.x);
                chk("frame_y", ft_y, e.y);
                chk("frame_dval", ft_dval, e.d);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t va, vb;

        //           r0 s0 e0  r1 s1 e1 gap  ex ey ed
        vecs[0] = '{ 3,  5, 10, -1, 0,  0, 0,  7, 3, 1};
        vecs[1] = '{ 2,  0,  2,  5, 12, 15, 0, 13, 5, 1};
        vecs[2] = '{-1,  0,  0, -1, 0,  0, 0, 13, 5, 0};
        vecs[3] = '{ 4,  6,  9, -1, 0,  0, 1,  7, 4, 1};
        vecs[4] = '{ 6,  0,  3,  6, 8, 15, 0,  1, 6, 1};
        vecs[5] = '{ 0, 13, 15,  1, 0,  0, 0,  1, 6, 0};
        vecs[6] = '{ 7, 12, 15, -1, 0,  0, 0, 13, 7, 1};
        vecs[7] = '{ 0,  0, 15, -1, 0,  0, 0,  7, 0, 1};
        vecs[8] = '{ 0,  4,  6,  7, 0,  3, 0,  1, 7, 1};

        rst         = 1'b1;
        frame_start = 1'b0;
        dval        = 1'b0;
        skin        = 1'b0;
        tick();
        tick();
        tick();
        chk("reset_x", ft_x, 0);
        chk("reset_y", ft_y, 0);
        chk("reset_dval", ft_dval, 0);
        chk("reset_frame_en", frame_en, 0);
        rst = 1'b0;
        tick();

        // Table-driven frames
        for (int k = 0; k < 9; k++) begin
            sb.push_back(mk_exp(vecs[k].ex, vecs[k].ey, vecs[k].ed));
            pulse_start();
            drive_pixels(vecs[k], NPIX);
            check_strobe_timing(k);
            tick();
        end

        // Frame start coincident with the last pixel: that frame is dropped
        va = '{3, 5, 10, -1, 0, 0, 0, 0, 0, 0};
        vb = '{6, 2, 5, -1, 0, 0, 0, 0, 0, 0};
        pulse_start();
        drive_pixels(va, NPIX - 1);
        frame_start = 1'b1;
        dval        = 1'b1;
        skin        = 1'b0;
        tick();
        frame_start = 1'b0;
        dval        = 1'b0;
        chk("start_at_last_no_strobe", frame_en, 0);
        sb.push_back(mk_exp(3, 6, 1));
        drive_pixels(vb, NPIX);
        check_strobe_timing(100);
        tick();

        // Mid-frame abort at pixel (8,3) after a run already locked
        va = '{0, 0, 5, -1, 0, 0, 0, 0, 0, 0};
        vb = '{1, 0, 3, -1, 0, 0, 0, 0, 0, 0};
        sb.push_back(mk_exp(1, 1, 1));
        pulse_start();
        drive_pixels(va, 3 * H + 8);
        pulse_start();
        drive_pixels(vb, NPIX);
        check_strobe_timing(101);
        tick();

        // Asynchronous reset while a run is in progress
        va = '{2, 0, 9, -1, 0, 0, 0, 0, 0, 0};
        pulse_start();
        drive_pixels(va, 2 * H + 7);
        rst = 1'b1;
        #2;
        chk("async_reset_x", ft_x, 0);
        chk("async_reset_y", ft_y, 0);
        chk("async_reset_dval", ft_dval, 0);
        chk("async_reset_frame_en", frame_en, 0);
        tick();
        rst = 1'b0;
        tick();
        // Pixels without a frame start must be ignored (no strobe expected)
        drive_pixels(va, NPIX);
        tick();
        chk("idle_pixels_no_strobe", frame_en, 0);
        chk("idle_pixels_x_held", ft_x, 0);
        sb.push_back(mk_exp(4, 2, 1));
        pulse_start();
        drive_pixels(va, NPIX);
        check_strobe_timing(102);
        tick();
        tick();

        chk("pending_strobes", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
